button_event_fsm: RTL and testbench



---
 rtl/btn_pkg.sv | 20 ++
 rtl/edge_det.sv | 32 +++
 rtl/button_event_fsm.sv | 154 +++++++++++++++
 tb/tb_button_event_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// ============================================================================
// Module   : btn_pkg
// Brief    : Shared types and constants for the button event logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
// Module   : edge_det
// Brief    : Rise/fall pulse generator for an already-synchronous level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Clearing to 0 means a level already high at reset release reads as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;
    assign o_fall = ~i_level & r_prev;

endmodule : edge_det

`default_nettype wire

// File: rtl/button_event_fsm.sv
// ============================================================================
// Module   : button_event_fsm
// Brief    : Turns a debounced switch level into press/release/long-press/
//            repeat pulses plus a wrapping press counter.
//            Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_event_fsm
    import btn_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 8
) (
    input  logic             Clk1ms,
    input  logic             Rst,
    input  logic             SwOutDB1,
    output logic             Press,
    output logic             Release,
    output logic             LongPress,
    output logic             Repeat,
    output logic             Held,
    output logic [CNT_W-1:0] PressCount
);

    if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long_ms
        $error("LONG_MS out of range 1..65535");
    end
    if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat_ms
        $error("REPEAT_MS out of range 1..65535");
    end

    localparam logic [TMR_W-1:0] c_long_ms = TMR_W'(LONG_MS);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [TMR_W-1:0] c_repeat_ms = TMR_W'(REPEAT_MS);
`endif

    logic             w_rise;
    logic             w_fall;
    logic [TMR_W-1:0] w_tmr_inc;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             r_press,   w_press_nxt;
    logic             r_release, w_release_nxt;
    logic             r_long,    w_long_nxt;
    logic             r_repeat,  w_repeat_nxt;
    logic             r_held,    w_held_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;

    edge_det u_edge_det (
        .clk     (Clk1ms),
        .rst     (Rst),
        .i_level (SwOutDB1),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Comparing the incremented value lets the pulse land exactly LONG_MS /
    // REPEAT_MS cycles after the cycle in which the timer was cleared.
    assign w_tmr_inc = r_tmr + TMR_W'(1);

    always_ff @(posedge Clk1ms or posedge Rst) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmr     <= w_tmr_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= w_held_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = r_tmr;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_held_nxt    = r_held;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_tmr_nxt   = '0;
                    w_press_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Fall is tested first so it wins a tie with the long-press point.
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_tmr_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (w_tmr_inc == c_long_ms) begin
                    w_state_nxt = LONG;
                    w_tmr_nxt   = '0;
                    w_long_nxt  = 1'b1;
                    w_held_nxt  = 1'b1;
                end else begin
                    w_tmr_nxt = w_tmr_inc;
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_tmr_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                end else if (w_tmr_inc == c_repeat_ms) begin
                    w_tmr_nxt    = '0;
                    w_repeat_nxt = 1'b1;
`endif
                end else begin
                    w_tmr_nxt = w_tmr_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = '0;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    assign Press      = r_press;
    assign Release    = r_release;
    assign LongPress  = r_long;
    assign Repeat     = r_repeat;
    assign Held       = r_held;
    assign PressCount = r_cnt;

endmodule : button_event_fsm

`default_nettype wire

// File: tb/tb_button_event_fsm.sv
// ============================================================================
// Module   : tb_button_event_fsm
// Brief    : Self-checking bench for button_event_fsm (LONG_MS=10, REPEAT_MS=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_event_fsm;

    localparam int L = 10;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw  = 1'b0;
    logic       press, rel, lng, rep, held;
    logic [7:0] cnt;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_cnt  = 8'd0;

    always #5 clk = ~clk;

    button_event_fsm #(
        .LONG_MS   (L),
        .REPEAT_MS (R),
        .CNT_W     (8)
    ) dut (
        .Clk1ms     (clk),
        .Rst        (rst),
        .SwOutDB1   (sw),
        .Press      (press),
        .Release    (rel),
        .LongPress  (lng),
        .Repeat     (rep),
        .Held       (held),
        .PressCount (cnt)
    );

    // Expected {Press,Release,LongPress,Repeat,Held} at offset i from the Press
    // cycle, for a switch held high n cycles.
    function automatic logic [4:0] exp_ev(int n, int i);
        logic p, r, l, rp, h;
        p  = (i == 0);
        r  = (i == n);
        l  = (n > L) && (i == L);
        h  = (n > L) && (i >= L) && (i < n);
        rp = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        rp = (n > L) && (i > L) && (i < n) && (((i - L) % R) == 0);
`endif
        return {p, r, l, rp, h};
    endfunction

    // Drive the level at a negedge, then sample at the following negedge.
    task automatic step(input logic v);
        sw = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        sw = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        exp_cnt = 8'd0;
        checks++;
        if ({press, rel, lng, rep, held} !== 5'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_in ev=%b exp=00000 cnt=%0d exp=0", {press, rel, lng, rep, held}, cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            checks++;
            if ({press, rel, lng, rep, held} !== 5'b0 || cnt !== 8'd0) begin
                failures++;
                $display("FAIL reset_idle i=%0d ev=%b exp=00000 cnt=%0d exp=0", i, {press, rel, lng, rep, held}, cnt);
            end
        end
    endtask

    task automatic test_short;
        for (int i = 0; i < 8; i++) begin
            step(i < 5);
            if (i == 0) exp_cnt++;
            checks++;
            if ({press, rel, lng, rep, held} !== exp_ev(5, i) || cnt !== exp_cnt) begin
                failures++;
                $display("FAIL short i=%0d ev=%b exp=%b cnt=%0d exp=%0d", i, {press, rel, lng, rep, held}, exp_ev(5, i), cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_long_repeat;
        for (int i = 0; i < 24; i++) begin
            step(i < 20);
            if (i == 0) exp_cnt++;
            checks++;
            if ({press, rel, lng, rep, held} !== exp_ev(20, i) || cnt !== exp_cnt) begin
                failures++;
                $display("FAIL long i=%0d ev=%b exp=%b cnt=%0d exp=%0d", i, {press, rel, lng, rep, held}, exp_ev(20, i), cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_coincide;
        int lens [2] = '{L, L + R};
        foreach (lens[t]) begin
            for (int i = 0; i < lens[t] + 3; i++) begin
                step(i < lens[t]);
                if (i == 0) exp_cnt++;
                checks++;
                if ({press, rel, lng, rep, held} !== exp_ev(lens[t], i) || cnt !== exp_cnt) begin
                    failures++;
                    $display("FAIL coincide n=%0d i=%0d ev=%b exp=%b cnt=%0d exp=%0d", lens[t], i, {press, rel, lng, rep, held}, exp_ev(lens[t], i), cnt, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int p = 0; p < 25; p++) begin
            int n   = int'($urandom_range(1, 30));
            int gap = int'($urandom_range(1, 4));
            for (int i = 0; i < n + gap; i++) begin
                step(i < n);
                if (i == 0) exp_cnt++;
                checks++;
                if ({press, rel, lng, rep, held} !== exp_ev(n, i) || cnt !== exp_cnt) begin
                    failures++;
                    $display("FAIL random n=%0d i=%0d ev=%b exp=%b cnt=%0d exp=%0d", n, i, {press, rel, lng, rep, held}, exp_ev(n, i), cnt, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_wrap;
        #2 rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        for (int p = 0; p < 257; p++) begin
            int n = int'($urandom_range(1, 3));
            for (int i = 0; i < n + 1; i++) begin
                step(i < n);
                if (i == 0) exp_cnt++;
                checks++;
                if ({press, rel, lng, rep, held} !== exp_ev(n, i) || cnt !== exp_cnt) begin
                    failures++;
                    $display("FAIL wrap p=%0d i=%0d ev=%b exp=%b cnt=%0d exp=%0d", p, i, {press, rel, lng, rep, held}, exp_ev(n, i), cnt, exp_cnt);
                end
            end
        end
        checks++;
        if (cnt !== 8'd1) begin
            failures++;
            $display("FAIL wrap_final cnt=%0d exp=1", cnt);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 13; i++) begin
            step(1'b1);
            if (i == 0) exp_cnt++;
            checks++;
            if ({press, rel, lng, rep, held} !== exp_ev(100, i) || cnt !== exp_cnt) begin
                failures++;
                $display("FAIL pre_rst i=%0d ev=%b exp=%b cnt=%0d exp=%0d", i, {press, rel, lng, rep, held}, exp_ev(100, i), cnt, exp_cnt);
            end
        end
        #2 rst = 1'b1;
        #1;
        exp_cnt = 8'd0;
        checks++;
        if ({press, rel, lng, rep, held} !== 5'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_rst ev=%b exp=00000 cnt=%0d exp=0", {press, rel, lng, rep, held}, cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            checks++;
            if ({press, rel, lng, rep, held} !== 5'b0 || cnt !== 8'd0) begin
                failures++;
                $display("FAIL rst_hold i=%0d ev=%b exp=00000 cnt=%0d exp=0", i, {press, rel, lng, rep, held}, cnt);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(i < 6);
            if (i == 0) exp_cnt++;
            checks++;
            if ({press, rel, lng, rep, held} !== exp_ev(6, i) || cnt !== exp_cnt) begin
                failures++;
                $display("FAIL post_rst i=%0d ev=%b exp=%b cnt=%0d exp=%0d", i, {press, rel, lng, rep, held}, exp_ev(6, i), cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long_repeat();
        test_coincide();
        test_random();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_button_event_fsm

`default_nettype wire
